// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns single commands into classic or incrementing-burst Wishbone cycles with streamed write/read data
module wb_cmd_master #(
  parameter int dw = 32,
  parameter int aw = 32
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [aw-1:0]   cmd_adr,
  input  logic [3:0]      cmd_len,
  input  logic            cmd_burst,
  input  logic            wdat_valid,
  output logic            wdat_ready,
  input  logic [dw-1:0]   wdat,
  input  logic [dw/8-1:0] wsel,
  output logic            rdat_valid,
  output logic [dw-1:0]   rdat,
  output logic            done,
  output logic [1:0]      status,
  output logic [aw-1:0]   wb_adr_o,
  output logic [dw-1:0]   wb_dat_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);
  typedef enum logic [2:0] {IDLE, WDATA, BUS, GAP, DONE} state_t;
  state_t          r_state;
  logic            r_burst;
  logic [3:0]      r_len;
  logic [3:0]      r_cnt;
  logic            w_last;
  logic            w_ack;
  logic            w_bwr;
  assign w_last = r_cnt == r_len;
  assign w_ack = r_state == BUS && wb_ack_i && !wb_err_i && !wb_rty_i;
  // a non-final burst-write ack may take the next word in the same cycle
  assign w_bwr = w_ack && r_burst && wb_we_o && !w_last;
  assign cmd_ready = wb_rst && r_state == IDLE;
  assign wdat_ready = r_state == WDATA || w_bwr;
  assign wb_cyc_o = r_state == BUS || r_state == GAP || (r_state == WDATA && r_cnt != 4'd0);
  assign wb_stb_o = r_state == BUS;
  assign wb_cti_o = (r_state == BUS && r_burst) ? (w_last ? 3'b111 : 3'b010) : 3'b000;
  assign wb_bte_o = 2'b00;
  assign done = r_state == DONE;
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_state    <= IDLE;
      r_burst    <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
      rdat       <= '0;
      rdat_valid <= 1'b0;
      status     <= 2'b00;
    end else begin
      rdat_valid <= 1'b0;
      case (r_state)
        IDLE: if (cmd_valid) begin
          wb_we_o  <= cmd_we;
          wb_adr_o <= cmd_adr;
          wb_sel_o <= cmd_we ? wb_sel_o : '1;
          r_len    <= cmd_len;
          r_burst  <= cmd_burst;
          r_cnt    <= '0;
          status   <= 2'b00;
          r_state  <= cmd_we ? WDATA : BUS;
        end
        WDATA: if (wdat_valid) begin
          wb_dat_o <= wdat;
          wb_sel_o <= wsel;
          r_state  <= BUS;
        end
        BUS: if (wb_err_i || wb_rty_i) begin
          status  <= wb_err_i ? 2'b01 : 2'b10;
          r_state <= DONE;
        end else if (wb_ack_i) begin
          if (!wb_we_o) begin
            rdat       <= wb_dat_i;
            rdat_valid <= 1'b1;
          end
          if (w_last) r_state <= DONE;
          else begin
            r_cnt    <= r_cnt + 4'd1;
            wb_adr_o <= wb_adr_o + aw'(dw / 8);
            if (w_bwr && wdat_valid) begin
              wb_dat_o <= wdat;
              wb_sel_o <= wsel;
            end
            r_state <= r_burst ? ((wb_we_o && !wdat_valid) ? WDATA : BUS) : (wb_we_o ? WDATA : GAP);
          end
        end
        GAP: r_state <= BUS;
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
